// File: rtl/program_loader_pkg.sv
// program_loader_pkg: BF opcode encodings and loader state type, shared with the control FSM.
`default_nettype none

package program_loader_pkg;

   localparam logic [3:0] c_OP_LEFT  = 4'b0000;
   localparam logic [3:0] c_OP_RIGHT = 4'b0001;
   localparam logic [3:0] c_OP_INC   = 4'b0010;
   localparam logic [3:0] c_OP_DEC   = 4'b0011;
   localparam logic [3:0] c_OP_OPEN  = 4'b0100;
   localparam logic [3:0] c_OP_CLOSE = 4'b0101;
   localparam logic [3:0] c_OP_OUT   = 4'b0110;
   localparam logic [3:0] c_OP_IN    = 4'b0111;
   localparam logic [3:0] c_OP_STOP  = 4'b1111;

   localparam logic [7:0] c_CHAR_LF  = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_ACCEPT = 3'd2,
      S_WRITE  = 3'd3,
      S_TERM   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bf_char_decoder.sv
// bf_char_decoder: combinational ASCII -> {is_bf, opcode}; non-BF characters give is_bf=0.
`default_nettype none

module bf_char_decoder
   import program_loader_pkg::*;
(
   input  logic [7:0] i_char,
   output logic       o_is_bf,
   output logic [3:0] o_opcode
);

   always_comb begin
      o_is_bf  = 1'b1;
      o_opcode = c_OP_STOP;
      case (i_char)
         8'h3C:   o_opcode = c_OP_LEFT;
         8'h3E:   o_opcode = c_OP_RIGHT;
         8'h2B:   o_opcode = c_OP_INC;
         8'h2D:   o_opcode = c_OP_DEC;
         8'h5B:   o_opcode = c_OP_OPEN;
         8'h5D:   o_opcode = c_OP_CLOSE;
         8'h2E:   o_opcode = c_OP_OUT;
         8'h2C:   o_opcode = c_OP_IN;
         default: o_is_bf  = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// program_loader: streams ASCII BF text into program memory from address 1, appends the
// stop opcode and reports length, capacity overflow and bracket balance.
`default_nettype none

module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load_start,
   input  logic              i_load_end,
   input  logic              i_char_valid,
   input  logic [7:0]        i_char_data,
   output logic              o_char_ready,
   output logic              o_prog_we,
   output logic [ADDR_W-1:0] o_prog_addr,
   output logic [3:0]        o_prog_wdata,
   output logic              o_busy,
   output logic              o_loaded,
   output logic [ADDR_W-1:0] o_prog_len,
   output logic              o_full,
   output logic              o_unbalanced
);

   localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 2);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_depth;
   logic                r_underflow;
   logic                r_full;
   logic [ADDR_W-1:0]   r_prog_len;
   logic [3:0]          r_opcode;

   logic                w_is_bf;
   logic [3:0]          w_opcode;
   logic                w_is_lf;
   logic                w_char_ready;
   logic                w_hs;

   bf_char_decoder u_dec (
      .i_char   (i_char_data),
      .o_is_bf  (w_is_bf),
      .o_opcode (w_opcode)
   );

   assign w_is_lf      = (i_char_data == c_CHAR_LF);
   // A load_start in ACCEPT discards the load, so no character is taken that cycle.
   assign w_char_ready = (r_state == S_ACCEPT) & ~i_load_end & ~i_load_start;
   assign w_hs         = i_char_valid & w_char_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_load_start) w_next = S_CLEAR;
         S_CLEAR:  w_next = S_ACCEPT;
         S_ACCEPT: begin
            if (i_load_start)      w_next = S_CLEAR;
            else if (i_load_end)   w_next = S_TERM;
            else if (w_hs) begin
               if (w_is_lf)        w_next = S_TERM;
               else if (w_is_bf)   w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (i_load_start)            w_next = S_CLEAR;
            else if (r_wr_ptr == c_LAST) w_next = S_TERM;
            else                         w_next = S_ACCEPT;
         end
         S_TERM:   w_next = i_load_start ? S_CLEAR : S_DONE;
         S_DONE:   if (i_load_start) w_next = S_CLEAR;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_depth     <= '0;
         r_underflow <= 1'b0;
         r_full      <= 1'b0;
         r_prog_len  <= '0;
         r_opcode    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_CLEAR: begin
               r_wr_ptr    <= c_ONE;
               r_depth     <= '0;
               r_underflow <= 1'b0;
               r_full      <= 1'b0;
               r_prog_len  <= '0;
            end
            S_ACCEPT: begin
               if (w_hs && w_is_bf) r_opcode <= w_opcode;
            end
            S_WRITE: begin
               r_wr_ptr <= r_wr_ptr + c_ONE;
               if (r_opcode == c_OP_OPEN) begin
                  if (r_depth != '1) r_depth <= r_depth + c_ONE;
               end else if (r_opcode == c_OP_CLOSE) begin
                  if (r_depth != '0) r_depth     <= r_depth - c_ONE;
                  else               r_underflow <= 1'b1;
               end
               if (r_wr_ptr == c_LAST) r_full <= 1'b1;
            end
            S_TERM: begin
               if (!i_load_start) r_prog_len <= r_wr_ptr - c_ONE;
            end
            default: ;
         endcase
      end
   end

   assign o_char_ready = w_char_ready;
   assign o_prog_we    = (r_state == S_WRITE) | (r_state == S_TERM);
   assign o_prog_addr  = o_prog_we ? r_wr_ptr : '0;
   assign o_prog_wdata = (r_state == S_WRITE) ? r_opcode :
                         (r_state == S_TERM)  ? c_OP_STOP : 4'b0000;
   assign o_busy       = (r_state == S_CLEAR) | (r_state == S_ACCEPT) |
                         (r_state == S_WRITE) | (r_state == S_TERM);
   assign o_loaded     = (r_state == S_DONE);
   assign o_prog_len   = r_prog_len;
   assign o_full       = r_full;
   assign o_unbalanced = o_loaded & ((r_depth != '0) | r_underflow);

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized and directed loads scored against a string-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_program_loader;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int CAP    = DEPTH - 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ls = 1'b0, le = 1'b0, cv = 1'b0;
   logic [7:0]        cd = 8'h00;
   logic              o_char_ready, o_prog_we, o_busy, o_loaded, o_full, o_unbalanced;
   logic [ADDR_W-1:0] o_prog_addr, o_prog_len;
   logic [3:0]        o_prog_wdata;

   program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_load_start (ls),
      .i_load_end   (le),
      .i_char_valid (cv),
      .i_char_data  (cd),
      .o_char_ready (o_char_ready),
      .o_prog_we    (o_prog_we),
      .o_prog_addr  (o_prog_addr),
      .o_prog_wdata (o_prog_wdata),
      .o_busy       (o_busy),
      .o_loaded     (o_loaded),
      .o_prog_len   (o_prog_len),
      .o_full       (o_full),
      .o_unbalanced (o_unbalanced)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {int addr; int data;} wr_t;
   typedef struct {int len; int full; int unb;} res_t;
   wr_t  wq[$];
   res_t rq[$];

   string OPS   = "<>+-[].,";
   string ALPHA = "<>+-[].,ab x";

   task automatic check(string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe and every rising loaded is scored against the queues.
   logic prev_loaded = 1'b0;
   always @(negedge clk) begin : monitor
      wr_t  e;
      res_t r;
      if (o_prog_we === 1'b1) begin
         if (wq.size() == 0) check("unexpected_write", 1, 0);
         else begin
            e = wq.pop_front();
            check("wr_addr", 32'(o_prog_addr), e.addr);
            check("wr_data", 32'(o_prog_wdata), e.data);
         end
      end
      if (o_loaded === 1'b1 && prev_loaded !== 1'b1) begin
         if (rq.size() == 0) check("unexpected_loaded", 1, 0);
         else begin
            r = rq.pop_front();
            check("prog_len", 32'(o_prog_len), r.len);
            check("full", 32'(o_full), r.full);
            check("unbalanced", 32'(o_unbalanced), r.unb);
         end
      end
      prev_loaded = o_loaded;
   end

   function automatic int opc(byte c);
      for (int k = 0; k < 8; k++) if (OPS[k] == c) return k;
      return -1;
   endfunction

   // Reference model: what a load of text s writes and reports.
   task automatic model(input string s, output int consumed, output bit ended, output bit full);
      int n = 0, opens = 0, closes = 0, o;
      bit under = 0;
      wr_t w;
      res_t r;
      consumed = s.len(); ended = 0; full = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (s[i] == 8'h0A) begin consumed = i + 1; ended = 1; break; end
         o = opc(s[i]);
         if (o >= 0) begin
            n++;
            w.addr = n; w.data = o; wq.push_back(w);
            if (o == 4) opens++;
            if (o == 5) closes++;
            if (closes > opens) under = 1;
            if (n == CAP) begin consumed = i + 1; ended = 1; full = 1; break; end
         end
      end
      w.addr = n + 1; w.data = 15; wq.push_back(w);
      r.len = n; r.full = full; r.unb = (under || opens != closes) ? 1 : 0;
      rq.push_back(r);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_char(byte c);
      bit got = 0;
      cv = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      cv = 1'b1; cd = c;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (o_char_ready) begin got = 1; step(); break; end
         step();
      end
      cv = 1'b0;
      if (!got) check("handshake_timeout", 1, 0);
   endtask

   task automatic wait_loaded();
      bit got = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (o_loaded) begin got = 1; break; end
      end
      if (!got) check("loaded_timeout", 1, 0);
      step();
   endtask

   task automatic run_load(input string s, input bit collide);
      int consumed;
      bit ended, full;
      model(s, consumed, ended, full);
      ls = 1'b1; step(); ls = 1'b0;
      @(negedge clk);
      check("busy_in_clear", 32'(o_busy), 1);
      check("loaded_drops", 32'(o_loaded), 0);
      step();
      for (int i = 0; i < consumed; i++) send_char(s[i]);
      if (full && consumed < s.len()) begin
         cv = 1'b1; cd = s[consumed];
         repeat (3) begin
            @(negedge clk);
            check("ready_after_full", 32'(o_char_ready), 0);
            step();
         end
         cv = 1'b0;
      end
      if (!ended) begin
         if (collide) begin cv = 1'b1; cd = OPS[$urandom_range(0, 7)]; end
         le = 1'b1;
         if (collide) begin
            @(negedge clk);
            check("ready_with_load_end", 32'(o_char_ready), 0);
         end
      end
      wait_loaded();
      le = 1'b0; cv = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s, t;
      wr_t w;
      repeat (3) step();
      @(negedge clk);
      check("rst_we", 32'(o_prog_we), 0);
      check("rst_addr", 32'(o_prog_addr), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_loaded", 32'(o_loaded), 0);
      check("rst_len", 32'(o_prog_len), 0);
      reset = 1'b0;
      step();

      run_load("+[->+<].\n", 0);
      run_load("a+ b-", 0);
      run_load("[[]", 0);
      run_load("][", 0);
      run_load("++++++++++++++++++++", 0);
      run_load("+", 1);

      // Reset while a write is in flight.
      ls = 1'b1; step(); ls = 1'b0; step();
      w.addr = 1; w.data = 2; wq.push_back(w);
      send_char("+");
      reset = 1'b1; step(); reset = 1'b0;
      @(negedge clk);
      check("rst_mid_we", 32'(o_prog_we), 0);
      check("rst_mid_addr", 32'(o_prog_addr), 0);
      check("rst_mid_data", 32'(o_prog_wdata), 0);
      check("rst_mid_busy", 32'(o_busy), 0);
      check("rst_mid_len", 32'(o_prog_len), 0);
      check("rst_mid_full", 32'(o_full), 0);
      check("rst_mid_ready", 32'(o_char_ready), 0);
      step();
      run_load("", 0);

      for (int n = 0; n < 25; n++) begin
         s = "";
         repeat ($urandom_range(0, 20)) begin
            t = " ";
            t.putc(0, ALPHA[$urandom_range(0, ALPHA.len() - 1)]);
            s = {s, t};
         end
         if ($urandom_range(0, 1)) s = {s, "\n"};
         run_load(s, 1'($urandom_range(0, 1)));
      end

      repeat (5) step();
      check("writes_drained", wq.size(), 0);
      check("results_drained", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
